// File: rtl/insn_fetch_ctrl.sv
// Instruction fetch sequencer: one single-beat AXI4 read at a time toward instruction
// memory, with IF/ID stall generation, stall-time buffering and redirect discard.
module insn_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        pipe_stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] araddr_o,
    output logic        arvalid_o,
    input  logic        arready_i,
    output logic [7:0]  arlen_o,
    output logic [2:0]  arsize_o,
    output logic [1:0]  arburst_o,
    input  logic [31:0] rdata_i,
    input  logic [1:0]  rresp_i,
    input  logic        rlast_i,
    input  logic        rvalid_i,
    output logic        rready_o,
    output logic [31:0] insn_o,
    output logic [31:0] fetch_pc_o,
    output logic        stall_im_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        ADDR = 2'd0,
        DATA = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] pc_reg, pc_next;
    logic [31:0] hold_insn_reg, hold_insn_next;
    logic [31:0] pend_pc_reg, pend_pc_next;
    logic        discard_reg, discard_next;

    logic        r_beat;
    logic        resp_err;
    logic [31:0] rx_insn;

    assign r_beat    = rvalid_i && rlast_i;
    assign resp_err  = (rresp_i != 2'b00);
    assign rx_insn   = resp_err ? NOP_INSN : rdata_i;

    assign araddr_o  = pc_reg;
    assign arlen_o   = 8'd0;
    assign arsize_o  = 3'b010;
    assign arburst_o = 2'b01;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= ADDR;
            pc_reg        <= RESET_PC;
            hold_insn_reg <= NOP_INSN;
            pend_pc_reg   <= RESET_PC;
            discard_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            pc_reg        <= pc_next;
            hold_insn_reg <= hold_insn_next;
            pend_pc_reg   <= pend_pc_next;
            discard_reg   <= discard_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        pc_next        = pc_reg;
        hold_insn_next = hold_insn_reg;
        pend_pc_next   = pend_pc_reg;
        discard_next   = discard_reg;
        arvalid_o      = 1'b0;
        rready_o       = 1'b0;
        stall_im_o     = 1'b1;
        insn_o         = hold_insn_reg;
        fetch_pc_o     = pc_reg;
        fetch_err_o    = 1'b0;

        case (state_reg)
            ADDR: begin
                arvalid_o = 1'b1;
                // The AR already on the bus cannot be withdrawn, so its data is marked stale.
                if (redirect_valid_i) begin
                    pend_pc_next = redirect_pc_i;
                    discard_next = 1'b1;
                end
                if (arready_i) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                rready_o = 1'b1;
                if (r_beat) begin
                    if (redirect_valid_i) begin
                        pc_next      = redirect_pc_i;
                        discard_next = 1'b0;
                        state_next   = ADDR;
                    end else if (discard_reg) begin
                        pc_next      = pend_pc_reg;
                        discard_next = 1'b0;
                        state_next   = ADDR;
                    end else begin
                        stall_im_o  = 1'b0;
                        insn_o      = rx_insn;
                        fetch_err_o = resp_err;
                        if (pipe_stall_i) begin
                            hold_insn_next = rx_insn;
                            state_next     = HOLD;
                        end else begin
                            pc_next    = pc_reg + 32'd4;
                            state_next = ADDR;
                        end
                    end
                end else if (redirect_valid_i) begin
                    pend_pc_next = redirect_pc_i;
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (redirect_valid_i) begin
                    pc_next    = redirect_pc_i;
                    state_next = ADDR;
                end else begin
                    stall_im_o = 1'b0;
                    if (!pipe_stall_i) begin
                        pc_next    = pc_reg + 32'd4;
                        state_next = ADDR;
                    end
                end
            end
            default: begin
                state_next = ADDR;
            end
        endcase

        // Outputs are forced quiet for as long as reset is held, independent of state.
        if (rst_i) begin
            arvalid_o   = 1'b0;
            rready_o    = 1'b0;
            stall_im_o  = 1'b1;
            insn_o      = NOP_INSN;
            fetch_pc_o  = RESET_PC;
            fetch_err_o = 1'b0;
        end
    end

endmodule
